// File: rtl/keypad_char_sequencer_pkg.sv
// Shared definitions for the keypad character sequencer:
//   ASCII control characters inserted at end of line and the FSM state type.
package keypad_char_sequencer_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_CHAR = 2'd1,
    SEND_CR   = 2'd2,
    SEND_LF   = 2'd3
  } state_e;

endpackage

// File: rtl/bin_to_ascii.sv
// bin_to_ascii: combinational hex digit to ASCII converter.
//   bin_i   : 4-bit value 0x0-0xF
//   ascii_o : '0'-'9' (0x30-0x39) or 'A'-'F' (0x41-0x46)
module bin_to_ascii (
  input  logic [3:0] bin_i,
  output logic [7:0] ascii_o
);

  // 'A' - 10 = 0x37, so letters share the same add-an-offset form as digits.
  always_comb begin
    if (bin_i < 4'd10) ascii_o = 8'h30 + {4'h0, bin_i};
    else               ascii_o = 8'h37 + {4'h0, bin_i};
  end

endmodule

// File: rtl/key_fifo.sv
// key_fifo: DEPTH x 4-bit synchronous FIFO for keypad codes.
//   clk_i/rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i/data_i : write request and data (ignored when full)
//   pop_i/data_o  : read request and head-of-queue data (ignored when empty)
//   full_o/empty_o/count_o : occupancy status, count is clog2(DEPTH)+1 bits
module key_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [3:0]    data_i,
  input  logic          pop_i,
  output logic [3:0]    data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Full/empty come from the registered count, so a push into a full FIFO is
  // refused even when a pop happens in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok) count_d = count_q + CW'(1);
    if (!push_ok && pop_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/keypad_char_sequencer.sv
// keypad_char_sequencer: buffers keypad codes, converts them to ASCII and
// offers them to a valid/ready sink, inserting CR,LF after every LINE_LEN chars.
//   clk, reset            : clock, synchronous active-high reset
//   key_valid, key_code   : one-cycle key strobe and 4-bit code
//   char_data, char_valid : character offered to the sink
//   char_ready            : sink accepts char_data this cycle
//   fifo_count            : keys currently buffered
//   overflow              : sticky, a key was dropped on a full FIFO
//   busy                  : FSM not idle or keys still buffered
module keypad_char_sequencer
  import keypad_char_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned LINE_LEN = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_valid,
  input  logic [3:0]             key_code,
  output logic [7:0]             char_data,
  output logic                   char_valid,
  input  logic                   char_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   busy
);

  state_e     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic [7:0] col_q, col_d;
  logic       ovf_q, ovf_d;

  logic       pop;
  logic       fifo_full, fifo_empty;
  logic [3:0] head;
  logic [7:0] head_ascii;
  logic       xfer, last_col;

  key_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (key_valid),
    .data_i  (key_code),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  bin_to_ascii u_b2a (
    .bin_i   (head),
    .ascii_o (head_ascii)
  );

  assign xfer     = valid_q && char_ready;
  assign last_col = (col_q == 8'(LINE_LEN - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      col_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      col_q   <= col_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!fifo_empty) state_d = SEND_CHAR;
      SEND_CHAR: if (xfer)        state_d = last_col ? SEND_CR : IDLE;
      SEND_CR:   if (xfer)        state_d = SEND_LF;
      SEND_LF:   if (xfer)        state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Outputs are registered: this block computes the next output register
  // contents and the FIFO pop, which only ever happens from IDLE.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    col_d   = col_q;
    pop     = 1'b0;
    ovf_d   = ovf_q || (key_valid && fifo_full);
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = head_ascii;
          valid_d = 1'b1;
        end
      end
      SEND_CHAR: begin
        if (xfer) begin
          if (last_col) begin
            col_d  = '0;
            data_d = ASCII_CR;
          end else begin
            col_d   = col_q + 8'd1;
            valid_d = 1'b0;
          end
        end
      end
      SEND_CR: if (xfer) data_d = ASCII_LF;
      SEND_LF: if (xfer) valid_d = 1'b0;
      default: valid_d = 1'b0;
    endcase
  end

  assign char_data  = data_q;
  assign char_valid = valid_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_keypad_char_sequencer.sv
module tb_keypad_char_sequencer;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned LINE_LEN = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       char_ready = 1'b0;
  logic [7:0] char_data;
  logic       char_valid;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  keypad_char_sequencer #(.DEPTH(DEPTH), .LINE_LEN(LINE_LEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: key queue + queue of chars to present
  logic [3:0] mq[$];
  logic [7:0] outq[$];
  int         mcol = 0;
  bit         movf = 1'b0;
  bit         mon_en = 1'b0;
  bit         m_full;
  logic [7:0] mc;

  function automatic logic [7:0] asc(input logic [3:0] k);
    if (k < 4'd10) return 8'h30 + {4'h0, k};
    return 8'h41 + ({4'h0, k} - 8'd10);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      outq.delete();
      mcol = 0;
      movf = 1'b0;
    end else begin
      m_full = (mq.size() == int'(DEPTH));
      if (outq.size() == 0) begin
        if (mq.size() != 0) outq.push_back(asc(mq.pop_front()));
      end else if (char_ready) begin
        mc = outq.pop_front();
        if (mc != 8'h0D && mc != 8'h0A) begin
          mcol++;
          if (mcol == int'(LINE_LEN)) begin
            mcol = 0;
            outq.push_back(8'h0D);
            outq.push_back(8'h0A);
          end
        end
      end
      if (key_valid) begin
        if (m_full) movf = 1'b1;
        else        mq.push_back(key_code);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("mdl_valid", char_valid, outq.size() != 0);
      if (outq.size() != 0) check("mdl_data", char_data, outq[0]);
      check("mdl_count", fifo_count, mq.size());
      check("mdl_overflow", overflow, movf);
      check("mdl_busy", busy, (outq.size() != 0) || (mq.size() != 0));
    end
  end

  // ---------------- stimulus helpers
  logic [3:0] push_q[$];
  logic [7:0] got[$];
  logic [7:0] exp_s[$];
  int         peak = 0;

  task automatic reset_dut();
    reset = 1'b1;
    key_valid = 1'b0;
    push_q.delete();
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_valid", char_valid, 0);
    check("rst_data", char_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    got.delete();
    peak = 0;
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      if (push_q.size() > 0) begin
        key_valid = 1'b1;
        key_code  = push_q.pop_front();
      end else begin
        key_valid = 1'b0;
      end
      @(negedge clk);
      if (char_valid && char_ready) got.push_back(char_data);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      @(posedge clk); #1;
    end
    key_valid = 1'b0;
  endtask

  task automatic check_stream(input string name);
    check({name, "_len"}, got.size(), exp_s.size());
    for (int i = 0; i < exp_s.size() && i < got.size(); i++) check(name, got[i], exp_s[i]);
  endtask

  typedef struct {
    logic [3:0] key;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[16];
  bit   found;

  initial begin
    for (int i = 0; i < 10; i++) begin
      tbl[i].key = 4'(i);
      tbl[i].exp = 8'h30 + 8'(i);
    end
    for (int i = 10; i < 16; i++) begin
      tbl[i].key = 4'(i);
      tbl[i].exp = 8'h41 + 8'(i - 10);
    end

    // Every code through the converter, with N+2 latency and a single transfer.
    for (int i = 0; i < 16; i++) begin
      reset_dut();
      char_ready = 1'b1;
      key_valid  = 1'b1;
      key_code   = tbl[i].key;
      @(negedge clk);
      check("lat_n_valid", char_valid, 0);
      @(posedge clk); #1;
      key_valid = 1'b0;
      @(negedge clk);
      check("lat_n1_valid", char_valid, 0);
      check("lat_n1_count", fifo_count, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("lat_n2_valid", char_valid, 1);
      check("lat_n2_data", char_data, tbl[i].exp);
      @(posedge clk); #1;
      @(negedge clk);
      check("after_xfer_valid", char_valid, 0);
      check("after_xfer_busy", busy, 0);
      @(posedge clk); #1;
    end

    // Back-to-back keys.
    reset_dut();
    char_ready = 1'b1;
    push_q = {4'h0, 4'hA, 4'hF};
    run(12);
    exp_s = {8'h30, 8'h41, 8'h46};
    check_stream("b2b_stream");
    check("b2b_peak_2_or_3", (peak >= 2 && peak <= 3), 1);
    check("b2b_final_count", fifo_count, 0);

    // Stall: data stable while not ready, then exactly one transfer.
    reset_dut();
    char_ready = 1'b0;
    push_q = {4'h5};
    run(3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_valid", char_valid, 1);
      check("stall_data", char_data, 8'h35);
      @(posedge clk); #1;
    end
    char_ready = 1'b1;
    run(4);
    exp_s = {8'h35};
    check_stream("stall_stream");

    // Line wrap after LINE_LEN=4 characters.
    reset_dut();
    char_ready = 1'b1;
    push_q = {4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    run(20);
    exp_s = {8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A, 8'h35};
    check_stream("wrap_stream");

    // Overflow: six keys with the sink stalled.
    reset_dut();
    char_ready = 1'b0;
    push_q = {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    run(8);
    @(negedge clk);
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_valid", char_valid, 1);
    check("ovf_data", char_data, 8'h31);
    @(posedge clk); #1;
    char_ready = 1'b1;
    run(20);
    exp_s = {8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A, 8'h35};
    check_stream("ovf_stream");
    @(negedge clk);
    check("ovf_sticky", overflow, 1);
    check("ovf_drained", fifo_count, 0);
    @(posedge clk); #1;

    // Reset while presenting CR with two keys queued.
    reset_dut();
    char_ready = 1'b1;
    push_q = {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (push_q.size() > 0) begin
        key_valid = 1'b1;
        key_code  = push_q.pop_front();
      end else begin
        key_valid = 1'b0;
      end
      @(negedge clk);
      if (char_valid && char_data == 8'h0D) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("cr_reached", found, 1);
    check("cr_queued", fifo_count, 2);
    key_valid  = 1'b0;
    char_ready = 1'b0;
    reset      = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_valid", char_valid, 0);
    check("midrst_data", char_data, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_overflow", overflow, 0);
    @(posedge clk); #1;
    char_ready = 1'b1;
    got.delete();
    push_q = {4'h7, 4'h8, 4'h9, 4'hA};
    run(20);
    exp_s = {8'h37, 8'h38, 8'h39, 8'h41, 8'h0D, 8'h0A};
    check_stream("midrst_col0_stream");

    // Random traffic against the model, with occasional resets.
    reset_dut();
    for (int c = 0; c < 1500; c++) begin
      key_valid  = ($urandom_range(0, 99) < 45);
      key_code   = 4'($urandom_range(0, 15));
      char_ready = ($urandom_range(0, 99) < 55);
      reset      = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    key_valid = 1'b0;
    reset_dut();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
